fetch_queue: RTL

//  Instruction-fetch stage between the PC register and decode. Takes pc, fetches the

---
 rtl/cpu_defs.sv | 19 +
 rtl/fq_fifo.sv | 54 +++++
 rtl/fetch_queue.sv | 102 ++++++++++
 3 files changed

// File: rtl/cpu_defs.sv
// Shared CPU definitions: reset vector, instruction width and the fetch-queue
// state encoding and FIFO entry layout used by the fetch stage.
package cpu_defs;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam int          INSTR_W  = 32;

  typedef enum logic [1:0] {
    FQ_IDLE = 2'd0,
    FQ_WAIT = 2'd1,
    FQ_DROP = 2'd2
  } fq_state_e;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fq_fifo.sv
// DEPTH-entry synchronous FIFO of {pc, instr} pairs. Clear beats push and pop;
// the head is read combinationally and reads as zero while empty.
module fq_fifo
  import cpu_defs::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  logic           pop,
  input  logic           clear,
  input  fq_entry_t      push_data,
  output fq_entry_t      head,
  output logic [PTR_W:0] count
);

  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

  fq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & (count != '0) & ~clear;
  assign do_push = push & ((count != FULL) | do_pop) & ~clear;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; entries are only visible once count covers them,
  // and the head is forced to zero while empty so reset outputs are still defined.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: issues one outstanding imem fetch at a time, buffers
// {pc, instr} pairs for decode and enables the PC register on accept or redirect.
module fetch_queue
  import cpu_defs::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        pc,
  output logic               pc_en,
  input  logic               flush,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [31:0]        id_pc
);

  fq_state_e      state;
  fq_state_e      state_nxt;
  logic [31:0]    req_pc;
  logic [PTR_W:0] count;
  logic           outstanding;
  logic           space;
  logic           accept;
  logic           push;
  logic           pop;
  fq_entry_t      head;
  logic           unused_pc_bits;

  // A fetch in flight (kept or being dropped) reserves a FIFO slot.
  assign outstanding = (state != FQ_IDLE);
  assign space       = (int'(count) + int'(outstanding)) < DEPTH;
  assign accept      = imem_req & imem_gnt;

  // NOTE: always_comb uses blocking assignments with every output defaulted first,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    push      = 1'b0;
    case (state)
      FQ_IDLE: begin
        imem_req = space & ~flush & ~reset;
        if (imem_req && imem_gnt) state_nxt = FQ_WAIT;
      end
      FQ_WAIT: begin
        if (flush) begin
          state_nxt = imem_rvalid ? FQ_IDLE : FQ_DROP;
        end else if (imem_rvalid) begin
          push      = 1'b1;
          state_nxt = FQ_IDLE;
        end
      end
      FQ_DROP: begin
        if (imem_rvalid) state_nxt = FQ_IDLE;
      end
      default: state_nxt = FQ_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= FQ_IDLE;
      req_pc <= '0;
    end else begin
      state <= state_nxt;
      if (accept) req_pc <= pc;
    end
  end

  assign pc_en     = flush | accept;
  assign imem_addr = {pc[31:2], 2'b00};
  assign pop       = id_valid & id_ready & ~flush;

  fq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .clear     (flush),
    .push_data ('{pc: req_pc, instr: imem_rdata}),
    .head      (head),
    .count     (count)
  );

  assign id_valid = (count != '0);
  assign id_instr = head.instr;
  assign id_pc    = head.pc;

  // Alignment of pc is the PC register's concern; the low bits are ignored here.
  assign unused_pc_bits = ^pc[1:0];

endmodule
